// File: rtl/alu_ctrl_seq_if.sv
// Handshake and decode bus between ID/EX and the ALU control sequencer.
interface alu_ctrl_seq_if #(
  parameter int unsigned CTRL_W = 5
);
  logic              flush;
  logic              in_valid;
  logic [5:0]        op;
  logic [5:0]        func;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              multi_cycle;
  logic              busy;

  // Upstream/consumer side.
  modport master (
    output flush, in_valid, op, func, out_ready,
    input  in_ready, out_valid, alu_ctrl, multi_cycle, busy
  );

  // Sequencer side.
  modport slave (
    input  flush, in_valid, op, func, out_ready,
    output in_ready, out_valid, alu_ctrl, multi_cycle, busy
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decode with multi-cycle (MULT/DIV) sequencing.
// Holds a decoded ALU code until the EX stage takes it; MULT/DIV
// class ops spend L-1 cycles in BUSY before presenting their code.
module alu_ctrl_seq #(
  parameter int unsigned       CTRL_W     = 5,
  parameter logic [CTRL_W-1:0] ADD_CODE   = CTRL_W'(6'h20),
  parameter int unsigned       MUL_CYCLES = 4,
  parameter int unsigned       DIV_CYCLES = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_ctrl_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_VALID} state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cnt, w_cnt_nxt;
  logic [CTRL_W-1:0] r_code, w_code_nxt;
  logic              r_mc, w_mc_nxt;

  logic [CTRL_W-1:0] w_code;
  logic              w_is_mul, w_is_div;
  logic [7:0]        w_lat;
  logic              w_in_ready;
  logic              w_accept;

  // Decode opcode/func into the ALU code and latency class.
  always_comb begin
    if (bus.op == 6'h23 || bus.op == 6'h2B)
      w_code = ADD_CODE;
    else if (bus.op != 6'h00)
      w_code = bus.op[CTRL_W-1:0];
    else
      w_code = bus.func[CTRL_W-1:0];
    w_is_mul = (bus.op == 6'h00) && (bus.func == 6'h18 || bus.func == 6'h19);
    w_is_div = (bus.op == 6'h00) && (bus.func == 6'h1A || bus.func == 6'h1B);
    if (w_is_mul)
      w_lat = 8'(MUL_CYCLES);
    else if (w_is_div)
      w_lat = 8'(DIV_CYCLES);
    else
      w_lat = 8'd1;
  end

  assign w_in_ready = (r_state == S_IDLE) || ((r_state == S_VALID) && bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = (r_state == S_VALID);
  assign bus.busy        = (r_state == S_BUSY);
  assign bus.alu_ctrl    = r_code;
  assign bus.multi_cycle = r_mc;

  // Next-state, counter and held-output computation; flush overrides all.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_mc_nxt    = r_mc;
    if (bus.flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_mc_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_BUSY: begin
          if (r_cnt == 8'd0)
            w_state_nxt = S_VALID;
          else
            w_cnt_nxt = r_cnt - 8'd1;
        end
        S_VALID: begin
          if (bus.out_ready && !w_accept) begin
            w_state_nxt = S_IDLE;
            w_mc_nxt    = 1'b0;
          end
        end
        default: ;
      endcase
      // Accept shares one load path for IDLE and VALID-with-out_ready;
      // counter starts at L-2 so out_valid rises L cycles after accept.
      if (w_accept) begin
        w_code_nxt = w_code;
        w_mc_nxt   = w_is_mul || w_is_div;
        if (w_lat <= 8'd1) begin
          w_state_nxt = S_VALID;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = w_lat - 8'd2;
        end
      end
    end
  end

  // State and held-output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_code  <= '0;
      r_mc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_code  <= w_code_nxt;
      r_mc    <= w_mc_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus random
// traffic compared against a timestamp-based reference model.
module tb_alu_ctrl_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_ctrl_seq_if #(.CTRL_W(5)) bus ();

  alu_ctrl_seq #(
    .CTRL_W(5),
    .MUL_CYCLES(4),
    .DIV_CYCLES(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: an op accepted in cycle n presents its result from
  // cycle n+L onward until taken.
  int         cyc = 0;
  bit         m_has = 1'b0;
  int         m_ready_at = 0;
  logic [4:0] m_code = 5'h00;
  bit         m_mc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [4:0] ref_code(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h23 || o == 6'h2B) return 5'h00;
    if (o != 6'h00) return o[4:0];
    return f[4:0];
  endfunction

  function automatic int ref_lat(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00 && (f == 6'h18 || f == 6'h19)) return 4;
    if (o == 6'h00 && (f == 6'h1A || f == 6'h1B)) return 8;
    return 1;
  endfunction

  // Called just after a falling edge: drive, check, advance model, wait next falling edge.
  task automatic step(input bit iv, input logic [5:0] o, input logic [5:0] f,
                      input bit ordy, input bit fl);
    bit m_ov, m_busy, m_ir, acc;
    bus.in_valid  = iv;
    bus.op        = o;
    bus.func      = f;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    m_ov   = m_has && (cyc >= m_ready_at);
    m_busy = m_has && (cyc <  m_ready_at);
    m_ir   = !m_has || (m_ov && ordy);
    check("out_valid",   32'(bus.out_valid),   32'(m_ov));
    check("busy",        32'(bus.busy),        32'(m_busy));
    check("in_ready",    32'(bus.in_ready),    32'(m_ir));
    check("alu_ctrl",    32'(bus.alu_ctrl),    32'(m_code));
    check("multi_cycle", 32'(bus.multi_cycle), 32'(m_mc));
    acc = iv && m_ir && !fl;
    if (fl) begin
      m_has = 1'b0;
      m_mc  = 1'b0;
    end else if (acc) begin
      m_has      = 1'b1;
      m_ready_at = cyc + ref_lat(o, f);
      m_code     = ref_code(o, f);
      m_mc       = (ref_lat(o, f) > 1);
    end else if (m_ov && ordy) begin
      m_has = 1'b0;
      m_mc  = 1'b0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
  endtask

  logic [5:0] op_tab [8];
  logic [5:0] fn_tab [6];

  initial begin
    op_tab = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h0D, 6'h08, 6'h0C};
    fn_tab = '{6'h20, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h22};
    bus.in_valid = 1'b0; bus.op = '0; bus.func = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;

    // Reset state while held in reset.
    #12;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_alu_ctrl",  32'(bus.alu_ctrl),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD single-cycle.
    step(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_code",  32'(bus.alu_ctrl),  32'h00);
    check("add_mc",    32'(bus.multi_cycle), 32'd0);

    // LW then SW back-to-back.
    step(1'b1, 6'h23, 6'h00, 1'b1, 1'b0);
    step(1'b1, 6'h2B, 6'h00, 1'b1, 1'b0);
    check("sw_valid", 32'(bus.out_valid), 32'd1);
    check("sw_code",  32'(bus.alu_ctrl),  32'h00);
    idle(1);

    // MULT: three busy cycles, valid on the fourth; new in_valid ignored.
    step(1'b1, 6'h00, 6'h18, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("mul_busy", 32'(bus.busy), 32'd1);
      step(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0);
    end
    check("mul_valid", 32'(bus.out_valid),   32'd1);
    check("mul_code",  32'(bus.alu_ctrl),    32'h18);
    check("mul_mc",    32'(bus.multi_cycle), 32'd1);
    idle(1);

    // ORI stalled by consumer for three cycles.
    step(1'b1, 6'h0D, 6'h00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 6'h08, 6'h00, 1'b0, 1'b0);
    check("ori_held", 32'(bus.alu_ctrl), 32'h0D);
    step(1'b1, 6'h08, 6'h00, 1'b1, 1'b0);
    check("addi_code", 32'(bus.alu_ctrl), 32'h08);
    idle(1);

    // DIV aborted by flush two cycles after accept, then ADD.
    step(1'b1, 6'h00, 6'h1A, 1'b1, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b1, 1'b1);
    check("flush_mc", 32'(bus.multi_cycle), 32'd0);
    step(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
    idle(10);

    // Reset pulse in the middle of a MULT.
    step(1'b1, 6'h00, 6'h19, 1'b1, 1'b0);
    step(1'b0, 6'h00, 6'h00, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("arst_busy",     32'(bus.busy),        32'd0);
    check("arst_in_ready", 32'(bus.in_ready),    32'd1);
    check("arst_alu_ctrl", 32'(bus.alu_ctrl),    32'd0);
    check("arst_mc",       32'(bus.multi_cycle), 32'd0);
    m_has = 1'b0; m_mc = 1'b0; m_code = 5'h00;
    @(negedge clk);
    cyc++;
    rst_n = 1'b1;
    idle(6);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      logic [5:0] o, f;
      o = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_tab[$urandom_range(0, 7)];
      f = ($urandom_range(0, 5) == 5) ? 6'($urandom) : fn_tab[$urandom_range(0, 5)];
      step(1'($urandom_range(0, 3) != 0), o, f,
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
